// File: rtl/wb_mem_access_unit.sv
// Single-outstanding pipelined Wishbone master for one CPU fetch/load/store.
// Steers byte/half/word lanes, checks alignment and aborts on bus timeout.
module wb_mem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned TIMEOUT_W      = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_enable,
   input  logic [31:0] i_addr,
   input  logic        i_we,
   input  logic [1:0]  i_data_width,
   input  logic [31:0] i_value,
   output logic [31:0] o_data,
   output logic        o_completed,
   output logic        o_exception,
   output logic        o_busy,
   output logic [31:0] o_wb_addr,
   output logic [31:0] o_wb_data,
   output logic [3:0]  o_wb_sel,
   output logic        o_wb_we,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   input  logic [31:0] i_wb_data,
   input  logic        i_wb_ack,
   input  logic        i_wb_stl
);

   typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StErr} state_t;

   localparam logic [TIMEOUT_W-1:0] TimeoutLast =
      (TIMEOUT_CYCLES == 0) ? '0 : TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   state_t               state_q, state_d;
   logic [31:0]          wb_addr_q;
   logic [31:0]          wb_data_q;
   logic [3:0]           wb_sel_q;
   logic                 we_q;
   logic [1:0]           width_q;
   logic [1:0]           off_q;
   logic [31:0]          rdata_q;
   logic [TIMEOUT_W-1:0] tcnt_q;

   logic        req_err;
   logic [3:0]  req_sel;
   logic [31:0] req_wdata;
   logic [31:0] rd_shift;
   logic [31:0] rd_ext;
   logic        timeout_hit;

   // Request decode straight from the CPU inputs, used only when latching in idle
   always_comb begin
      req_err   = 1'b0;
      req_sel   = 4'b1111;
      req_wdata = i_value;
      unique case (i_data_width)
         2'b00: begin
            req_sel   = 4'b0001 << i_addr[1:0];
            req_wdata = {4{i_value[7:0]}};
         end
         2'b01: begin
            req_err   = i_addr[0];
            req_sel   = 4'b0011 << i_addr[1:0];
            req_wdata = {2{i_value[15:0]}};
         end
         2'b10: req_err = 1'b1;
         default: req_err = (i_addr[1:0] != 2'b00);
      endcase
   end

   always_comb begin
      rd_shift = i_wb_data >> {off_q, 3'b000};
      rd_ext   = i_wb_data;
      unique case (width_q)
         2'b00:   rd_ext = {24'h0, rd_shift[7:0]};
         2'b01:   rd_ext = {16'h0, rd_shift[15:0]};
         default: rd_ext = i_wb_data;
      endcase
   end

   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt_q == TimeoutLast);

   // A same-cycle ack always beats timeout expiry
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (i_enable) state_d = req_err ? StErr : StReq;
         StReq: begin
            if (!i_wb_stl && i_wb_ack) state_d = StDone;
            else if (timeout_hit)      state_d = StErr;
            else if (!i_wb_stl)        state_d = StWait;
         end
         StWait: begin
            if (i_wb_ack)         state_d = StDone;
            else if (timeout_hit) state_d = StErr;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         wb_addr_q <= '0;
         wb_data_q <= '0;
         wb_sel_q  <= '0;
         we_q      <= 1'b0;
         width_q   <= '0;
         off_q     <= '0;
         rdata_q   <= '0;
         tcnt_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && i_enable) begin
            wb_addr_q <= {i_addr[31:2], 2'b00};
            wb_data_q <= req_wdata;
            wb_sel_q  <= req_sel;
            we_q      <= i_we;
            width_q   <= i_data_width;
            off_q     <= i_addr[1:0];
         end
         if (state_d == StDone && !we_q) rdata_q <= rd_ext;
         if (state_q == StIdle)                              tcnt_q <= '0;
         else if (state_q == StReq || state_q == StWait)     tcnt_q <= tcnt_q + 1'b1;
      end
   end

   assign o_data      = rdata_q;
   assign o_completed = (state_q == StDone);
   assign o_exception = (state_q == StErr);
   assign o_busy      = (state_q != StIdle);
   assign o_wb_addr   = wb_addr_q;
   assign o_wb_data   = wb_data_q;
   assign o_wb_sel    = wb_sel_q;
   assign o_wb_we     = we_q;
   assign o_wb_cyc    = (state_q == StReq) || (state_q == StWait);
   assign o_wb_stb    = (state_q == StReq);

endmodule

// File: tb/tb_wb_mem_access_unit.sv
// Directed bench for wb_mem_access_unit: vector table plus stall, timeout,
// busy and reset sequences, run with a 4-cycle timeout.
module tb_wb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_enable;
   logic [31:0] i_addr;
   logic        i_we;
   logic [1:0]  i_data_width;
   logic [31:0] i_value;
   logic [31:0] o_data;
   logic        o_completed;
   logic        o_exception;
   logic        o_busy;
   logic [31:0] o_wb_addr;
   logic [31:0] o_wb_data;
   logic [3:0]  o_wb_sel;
   logic        o_wb_we;
   logic        o_wb_cyc;
   logic        o_wb_stb;
   logic [31:0] i_wb_data;
   logic        i_wb_ack;
   logic        i_wb_stl;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   wb_mem_access_unit #(
      .TIMEOUT_CYCLES(4),
      .TIMEOUT_W(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .i_enable(i_enable),
      .i_addr(i_addr),
      .i_we(i_we),
      .i_data_width(i_data_width),
      .i_value(i_value),
      .o_data(o_data),
      .o_completed(o_completed),
      .o_exception(o_exception),
      .o_busy(o_busy),
      .o_wb_addr(o_wb_addr),
      .o_wb_data(o_wb_data),
      .o_wb_sel(o_wb_sel),
      .o_wb_we(o_wb_we),
      .o_wb_cyc(o_wb_cyc),
      .o_wb_stb(o_wb_stb),
      .i_wb_data(i_wb_data),
      .i_wb_ack(i_wb_ack),
      .i_wb_stl(i_wb_stl)
   );

   typedef struct {
      logic [1:0]  width;
      logic        we;
      logic [31:0] addr;
      logic [31:0] value;
      logic [31:0] rdata;
      logic        err;
      logic [3:0]  sel;
      logic [31:0] wdata;
      logic [31:0] odata;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [1:0] w, input logic we, input logic [31:0] a,
                        input logic [31:0] v);
      i_enable     = 1'b1;
      i_data_width = w;
      i_we         = we;
      i_addr       = a;
      i_value      = v;
   endtask

   // Word load at 0x6000 with no stall; ack only in cycle ack_cyc (-1: never)
   task automatic run_timeout(input int ack_cyc, input int exp_cyc, input int exp_exc,
                              input int exp_cmp);
      int cyc_n = 0;
      int exc_n = 0;
      int cmp_n = 0;
      i_wb_stl  = 1'b0;
      i_wb_ack  = 1'b0;
      i_wb_data = 32'h0bad_f00d;
      start(2'b11, 1'b0, 32'h0000_6000, 32'h0);
      tick();
      i_enable = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cyc_n += int'(o_wb_cyc);
         exc_n += int'(o_exception);
         cmp_n += int'(o_completed);
         i_wb_ack = (i == ack_cyc);
         tick();
      end
      i_wb_ack = 1'b0;
      check("to_cyc_cycles", cyc_n, exp_cyc);
      check("to_exc_pulses", exc_n, exp_exc);
      check("to_cmp_pulses", cmp_n, exp_cmp);
      check("to_idle_busy", o_busy, 0);
   endtask

   initial begin
      vecs[0] = '{2'b11, 1'b0, 32'h0000_0100, 32'h0,         32'h1122_3344, 1'b0, 4'b1111,
                  32'h0,         32'h1122_3344};
      vecs[1] = '{2'b00, 1'b1, 32'h0000_1003, 32'h0000_00a5, 32'h7777_7777, 1'b0, 4'b1000,
                  32'ha5a5_a5a5, 32'h1122_3344};
      vecs[2] = '{2'b01, 1'b0, 32'h0000_2002, 32'h0,         32'h8123_4567, 1'b0, 4'b1100,
                  32'h0,         32'h0000_8123};
      vecs[3] = '{2'b00, 1'b0, 32'h0000_2001, 32'h0,         32'h8123_4567, 1'b0, 4'b0010,
                  32'h0,         32'h0000_0045};
      vecs[4] = '{2'b01, 1'b1, 32'h0000_4000, 32'hffff_beef, 32'h0,         1'b0, 4'b0011,
                  32'hbeef_beef, 32'h0000_0045};
      vecs[5] = '{2'b11, 1'b1, 32'h0000_5004, 32'hcafe_f00d, 32'h9999_9999, 1'b0, 4'b1111,
                  32'hcafe_f00d, 32'h0000_0045};
      vecs[6] = '{2'b11, 1'b0, 32'h0000_3001, 32'h0,         32'h0,         1'b1, 4'b0000,
                  32'h0,         32'h0000_0045};
      vecs[7] = '{2'b01, 1'b0, 32'h0000_3003, 32'h0,         32'h0,         1'b1, 4'b0000,
                  32'h0,         32'h0000_0045};
      vecs[8] = '{2'b10, 1'b0, 32'h0000_3000, 32'h0,         32'h0,         1'b1, 4'b0000,
                  32'h0,         32'h0000_0045};
      vecs[9] = '{2'b00, 1'b0, 32'h0000_3000, 32'h0,         32'h8123_4567, 1'b0, 4'b0001,
                  32'h0,         32'h0000_0067};

      reset        = 1'b0;
      i_enable     = 1'b0;
      i_addr       = '0;
      i_we         = 1'b0;
      i_data_width = 2'b00;
      i_value      = '0;
      i_wb_data    = '0;
      i_wb_ack     = 1'b0;
      i_wb_stl     = 1'b0;
      #1;
      check("rst_busy", o_busy, 0);
      check("rst_cyc", o_wb_cyc, 0);
      check("rst_stb", o_wb_stb, 0);
      check("rst_data", o_data, 0);
      check("rst_sel", o_wb_sel, 0);
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
      tick();

      // Zero-stall, same-cycle-ack transactions; ack stays high into idle
      for (int v = 0; v < 10; v++) begin
         start(vecs[v].width, vecs[v].we, vecs[v].addr, vecs[v].value);
         i_wb_ack  = 1'b1;
         i_wb_stl  = 1'b0;
         i_wb_data = vecs[v].rdata;
         tick();
         i_enable = 1'b0;
         if (vecs[v].err) begin
            check($sformatf("v%0d_exc", v), o_exception, 1);
            check($sformatf("v%0d_cyc", v), o_wb_cyc, 0);
            check($sformatf("v%0d_cmp", v), o_completed, 0);
            tick();
            check($sformatf("v%0d_exc_end", v), o_exception, 0);
            check($sformatf("v%0d_cyc_end", v), o_wb_cyc, 0);
            check($sformatf("v%0d_busy_end", v), o_busy, 0);
            check($sformatf("v%0d_odata", v), o_data, vecs[v].odata);
         end else begin
            check($sformatf("v%0d_cyc", v), o_wb_cyc, 1);
            check($sformatf("v%0d_stb", v), o_wb_stb, 1);
            check($sformatf("v%0d_addr", v), o_wb_addr, {vecs[v].addr[31:2], 2'b00});
            check($sformatf("v%0d_sel", v), o_wb_sel, vecs[v].sel);
            check($sformatf("v%0d_we", v), o_wb_we, vecs[v].we);
            if (vecs[v].we) check($sformatf("v%0d_wdata", v), o_wb_data, vecs[v].wdata);
            tick();
            check($sformatf("v%0d_cmp", v), o_completed, 1);
            check($sformatf("v%0d_exc", v), o_exception, 0);
            check($sformatf("v%0d_done_cyc", v), o_wb_cyc, 0);
            check($sformatf("v%0d_done_busy", v), o_busy, 1);
            check($sformatf("v%0d_odata", v), o_data, vecs[v].odata);
            tick();
            check($sformatf("v%0d_idle_busy", v), o_busy, 0);
            check($sformatf("v%0d_idle_cmp", v), o_completed, 0);
         end
      end
      i_wb_ack = 1'b0;

      // Word load with two stall cycles and ack one cycle after acceptance
      i_wb_stl = 1'b1;
      start(2'b11, 1'b0, 32'hb000_0010, 32'h0);
      tick();
      i_enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("st_stb%0d", i), o_wb_stb, 1);
         check($sformatf("st_addr%0d", i), o_wb_addr, 32'hb000_0010);
         check($sformatf("st_sel%0d", i), o_wb_sel, 4'b1111);
         if (i == 2) i_wb_stl = 1'b0;
         tick();
      end
      check("st_wait_stb", o_wb_stb, 0);
      check("st_wait_cyc", o_wb_cyc, 1);
      i_wb_ack  = 1'b1;
      i_wb_data = 32'hdead_beef;
      tick();
      i_wb_ack = 1'b0;
      check("st_cmp", o_completed, 1);
      check("st_data", o_data, 32'hdead_beef);
      tick();
      check("st_cmp_once", o_completed, 0);

      run_timeout(-1, 4, 1, 0);
      run_timeout(3, 4, 0, 1);
      check("to_ack_data", o_data, 32'h0bad_f00d);

      // Enable pulsed during WAIT must be ignored and not queued
      start(2'b11, 1'b0, 32'h0000_7000, 32'h0);
      tick();
      i_enable = 1'b0;
      tick();
      start(2'b11, 1'b0, 32'h0000_8000, 32'h0);
      tick();
      i_enable = 1'b0;
      check("bz_addr", o_wb_addr, 32'h0000_7000);
      check("bz_cyc", o_wb_cyc, 1);
      i_wb_ack  = 1'b1;
      i_wb_data = 32'h1234_5678;
      tick();
      i_wb_ack = 1'b0;
      check("bz_cmp", o_completed, 1);
      check("bz_data", o_data, 32'h1234_5678);
      tick();
      tick();
      check("bz_no_queue", o_busy, 0);
      check("bz_no_queue_cyc", o_wb_cyc, 0);

      // Reset asserted during WAIT
      start(2'b11, 1'b0, 32'h0000_7000, 32'h0);
      tick();
      i_enable = 1'b0;
      tick();
      check("rw_cyc_pre", o_wb_cyc, 1);
      #2 reset = 1'b0;
      #1;
      check("rw_cyc", o_wb_cyc, 0);
      check("rw_stb", o_wb_stb, 0);
      check("rw_busy", o_busy, 0);
      check("rw_data", o_data, 0);
      check("rw_addr", o_wb_addr, 0);
      check("rw_cmp", o_completed, 0);
      check("rw_exc", o_exception, 0);
      @(posedge clk);
      #3 reset = 1'b1;
      tick();
      check("rw_post_cmp", o_completed, 0);
      check("rw_post_exc", o_exception, 0);
      start(2'b11, 1'b0, 32'h0000_9000, 32'h0);
      i_wb_ack  = 1'b1;
      i_wb_data = 32'h5a5a_1234;
      tick();
      i_enable = 1'b0;
      check("rw_new_addr", o_wb_addr, 32'h0000_9000);
      tick();
      i_wb_ack = 1'b0;
      check("rw_new_cmp", o_completed, 1);
      check("rw_new_data", o_data, 32'h5a5a_1234);
      tick();
      check("rw_new_idle", o_busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // The two result pulses must never coincide
   always @(negedge clk) begin
      if (reset && o_completed && o_exception) begin
         n_cmp++;
         n_bad++;
         $display("FAIL pulse_overlap: got both high want exclusive");
      end
   end

endmodule
